core_branch_unit: RTL and testbench



---
 rtl/core_branch_unit_pkg.sv | 55 +++++
 rtl/core_pipe_if.sv | 48 ++++
 rtl/core_branch_unit_bht.sv | 39 +++
 rtl/core_branch_unit.sv | 87 ++++++++
 tb/tb_core_branch_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/core_branch_unit_pkg.sv
// ---------------------------------------------------------------------------
// rv : branch funct3 encodings, predictor counter type and condition helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rv;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3b_t;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t BP_CTR_RESET = 2'b01;

  // Encodings 010/011 are not branches and always evaluate false.
  function automatic logic branch_cond_true(
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic r;
    r = 1'b0;
    case (f3)
      F3_BEQ:  r = (a == b);
      F3_BNE:  r = (a != b);
      F3_BLT:  r = ($signed(a) <  $signed(b));
      F3_BGE:  r = ($signed(a) >= $signed(b));
      F3_BLTU: r = (a <  b);
      F3_BGEU: r = (a >= b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t c, input logic taken);
    bp_ctr_t n;
    n = c;
    if (taken && c != 2'b11) begin
      n = c + 2'b01;
    end else if (!taken && c != 2'b00) begin
      n = c - 2'b01;
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_pipe_if.sv
// ---------------------------------------------------------------------------
// f_if / d_if / x_if : fetch, decode and execute pipeline interfaces
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface f_if;
  logic [31:0] pc_new;
  logic        pc_load;

  modport branch (output pc_new, output pc_load);
  modport fetch  (input  pc_new, input  pc_load);
endinterface

interface d_if;
  logic        valid;
  logic        ready;
  logic [31:0] pc;
  logic        is_branch;
  logic [31:0] imm;
  logic        flush;
  logic        predicted_taken;

  modport branch (
    input  valid, input ready, input pc, input is_branch, input imm,
    output flush, output predicted_taken
  );
endinterface

interface x_if;
  logic        valid;
  logic        ready;
  logic [31:0] pc;
  logic [31:0] pc_new;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        is_jump;
  logic        is_branch;
  logic [2:0]  branch_cond;
  logic        predicted_taken;

  modport branch (
    input valid, input pc, input pc_new, input rs1, input rs2,
    input is_jump, input is_branch, input branch_cond, input predicted_taken
  );
endinterface

`default_nettype wire

// File: rtl/core_branch_unit_bht.sv
// ---------------------------------------------------------------------------
// core_bht : array of 2-bit saturating counters, async read, one update port
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module core_bht
  import rv::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output bp_ctr_t          rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bp_ctr_t ctr [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= BP_CTR_RESET;
      end
    end else if (wr_en) begin
      ctr[wr_idx] <= bp_ctr_next(ctr[wr_idx], wr_taken);
    end
  end

  // No bypass: a same-cycle read of the entry being written sees the old value.
  assign rd_ctr = ctr[rd_idx];

endmodule

`default_nettype wire

// File: rtl/core_branch_unit.sv
// ---------------------------------------------------------------------------
// core_branch_unit : decode-stage prediction, execute-stage resolution/redirect
// Optional predictor table enabled by CORE_BRANCH_PREDICT_EN.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module core_branch_unit
  import rv::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  f_if.branch         f,
  d_if.branch         d,
  x_if.branch         x,
  input  logic        x_advance,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
);

  logic        x_cond;
  logic        x_taken;
  logic        x_mispredict;
  logic        x_redirect;
  logic        x_resolve;
  logic        d_pred;
  logic [31:0] x_target;

  assign x_cond       = branch_cond_true(x.branch_cond, x.rs1, x.rs2);
  assign x_taken      = x.is_jump | (x.is_branch & x_cond);
  assign x_mispredict = x.is_branch & (x_taken != x.predicted_taken);
  // Jumps are never predicted, so every valid jump redirects.
  assign x_redirect   = x.valid & (x.is_jump | x_mispredict);
  assign x_target     = x_taken ? x.pc_new : (x.pc + 32'd4);
  assign x_resolve    = x_advance & x.is_branch;

`ifdef CORE_BRANCH_PREDICT_EN
  bp_ctr_t d_ctr;

  core_bht #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (d.pc[IDX_W+1:2]),
    .rd_ctr   (d_ctr),
    .wr_en    (x_resolve),
    .wr_idx   (x.pc[IDX_W+1:2]),
    .wr_taken (x_taken)
  );

  assign d_pred = d.valid & d.is_branch & d_ctr[1];
`else
  assign d_pred = 1'b0;
`endif

  assign d.predicted_taken = d_pred;
  assign d.flush           = x_redirect;
  assign f.pc_load         = x_redirect | d_pred;

  always_comb begin
    f.pc_new = 32'd0;
    if (x_redirect) begin
      f.pc_new = x_target;
    end else if (d_pred) begin
      f.pc_new = d.pc + d.imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches    <= 32'd0;
      perf_mispredicts <= 32'd0;
    end else if (x_resolve) begin
      perf_branches <= perf_branches + 32'd1;
      if (x_mispredict) begin
        perf_mispredicts <= perf_mispredicts + 32'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_core_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_core_branch_unit : directed vectors with a queue-based scoreboard
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_core_branch_unit;

`ifdef CORE_BRANCH_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  logic        clk;
  logic        rst_n;
  logic        adv;
  logic [31:0] perf_b;
  logic [31:0] perf_m;
  logic        chk_en;

  f_if f();
  d_if d();
  x_if x();

  core_branch_unit #(.BHT_ENTRIES(64)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .f                (f),
    .d                (d),
    .x                (x),
    .x_advance        (adv),
    .perf_branches    (perf_b),
    .perf_mispredicts (perf_m)
  );

  typedef struct {
    string       name;
    logic        pl;
    logic [31:0] pn;
    logic        fl;
    logic        pr;
    logic [31:0] br;
    logic [31:0] mp;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per marked cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL no_expectation: output presented with empty scoreboard");
      end else begin
        cur = q.pop_front();
        if ({f.pc_load, f.pc_new, d.flush, d.predicted_taken, perf_b, perf_m} !==
            {cur.pl, cur.pn, cur.fl, cur.pr, cur.br, cur.mp}) begin
          errors++;
          $display("FAIL %s: got pc_load=%0b pc_new=%h flush=%0b pred=%0b br=%0d mp=%0d, expected pc_load=%0b pc_new=%h flush=%0b pred=%0b br=%0d mp=%0d",
                   cur.name, f.pc_load, f.pc_new, d.flush, d.predicted_taken, perf_b, perf_m,
                   cur.pl, cur.pn, cur.fl, cur.pr, cur.br, cur.mp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clr();
    adv = 1'b0;
    d.valid = 1'b0; d.ready = 1'b0; d.pc = 32'd0; d.is_branch = 1'b0; d.imm = 32'd0;
    x.valid = 1'b0; x.ready = 1'b0; x.pc = 32'd0; x.pc_new = 32'd0;
    x.rs1 = 32'd0; x.rs2 = 32'd0; x.is_jump = 1'b0; x.is_branch = 1'b0;
    x.branch_cond = 3'b000; x.predicted_taken = 1'b0;
  endtask

  task automatic xb(input logic [31:0] pc, input logic [31:0] pcn, input logic [31:0] a,
                    input logic [31:0] b, input logic [2:0] cond, input logic pred,
                    input logic a_adv);
    x.valid = 1'b1; x.ready = a_adv; adv = a_adv; x.pc = pc; x.pc_new = pcn;
    x.rs1 = a; x.rs2 = b; x.is_branch = 1'b1; x.is_jump = 1'b0;
    x.branch_cond = cond; x.predicted_taken = pred;
  endtask

  task automatic xj(input logic [31:0] pc, input logic [31:0] pcn, input logic a_adv);
    x.valid = 1'b1; x.ready = a_adv; adv = a_adv; x.pc = pc; x.pc_new = pcn;
    x.is_jump = 1'b1; x.is_branch = 1'b0; x.predicted_taken = 1'b0;
  endtask

  task automatic dset(input logic [31:0] pc, input logic [31:0] imm);
    d.valid = 1'b1; d.ready = 1'b1; d.pc = pc; d.imm = imm; d.is_branch = 1'b1;
  endtask

  task automatic chk(input string nm, input logic pl, input logic [31:0] pn, input logic fl,
                     input logic pr, input logic [31:0] br, input logic [31:0] mp);
    exp_t e;
    e.name = nm; e.pl = pl; e.pn = pn; e.fl = fl; e.pr = pr; e.br = br; e.mp = mp;
    q.push_back(e);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b0;
  endtask

  initial begin
    chk_en = 1'b0;
    rst_n  = 1'b0;
    clr();
    @(posedge clk);
    #1;
    chk("reset", 0, 32'h0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Predictor entry for pc 0x100 walks 1->2->3->3->2 through these.
    clr(); xb(32'h100, 32'h140, 32'd5, 32'd5, BEQ, 1'b0, 1'b1);
    chk("beq_x_taken", 1, 32'h140, 1, 0, 0, 0);
    clr(); dset(32'h100, 32'h40);
    chk("beq_d_pred", PRED, PRED ? 32'h140 : 32'h0, 0, PRED, 1, 1);
    clr(); xb(32'h100, 32'h140, 32'd5, 32'd5, BEQ, PRED, 1'b1);
    chk("beq_x_hit", !PRED, PRED ? 32'h0 : 32'h140, !PRED, 0, 1, 1);
    clr(); xb(32'h100, 32'h140, 32'd5, 32'd5, BEQ, PRED, 1'b1);
    chk("beq_x_sat", !PRED, PRED ? 32'h0 : 32'h140, !PRED, 0, 2, PRED ? 1 : 2);
    clr(); dset(32'h100, 32'h40);
    chk("beq_d_strong", PRED, PRED ? 32'h140 : 32'h0, 0, PRED, 3, PRED ? 1 : 3);
    clr(); xb(32'h100, 32'h140, 32'd5, 32'd6, BEQ, PRED, 1'b1);
    chk("beq_x_nt", PRED, PRED ? 32'h104 : 32'h0, PRED, 0, 3, PRED ? 1 : 3);
    clr(); dset(32'h100, 32'h40);
    chk("beq_d_weak", PRED, PRED ? 32'h140 : 32'h0, 0, PRED, 4, PRED ? 2 : 3);

    clr(); xb(32'h200, 32'h280, 32'hFFFF_FFFF, 32'd1, BLT, 1'b0, 1'b1);
    chk("blt_signed", 1, 32'h280, 1, 0, 4, PRED ? 2 : 3);
    clr(); xb(32'h300, 32'h380, 32'hFFFF_FFFF, 32'd1, BLTU, 1'b1, 1'b1);
    chk("bltu_unsigned", 1, 32'h304, 1, 0, 5, PRED ? 3 : 4);

    clr(); xj(32'h400, 32'h2000, 1'b1); dset(32'h100, 32'h40);
    chk("jal_over_dpred", 1, 32'h2000, 1, PRED, 6, PRED ? 4 : 5);
    clr(); xb(32'h100, 32'h140, 32'd5, 32'd6, BEQ, PRED, 1'b1);
    chk("beq_x_nt2", PRED, PRED ? 32'h104 : 32'h0, PRED, 0, 6, PRED ? 4 : 5);
    clr(); dset(32'h100, 32'h40);
    chk("jal_no_update", 0, 32'h0, 0, 0, 7, 5);

    for (int i = 0; i < 3; i++) begin
      clr(); xb(32'h500, 32'h580, 32'd1, 32'd2, BNE, 1'b0, 1'b0);
      chk("stall_hold", 1, 32'h580, 1, 0, 7, 5);
    end
    clr(); xb(32'h500, 32'h580, 32'd1, 32'd2, BNE, 1'b0, 1'b1);
    chk("stall_advance", 1, 32'h580, 1, 0, 7, 5);
    clr();
    chk("idle_after_stall", 0, 32'h0, 0, 0, 8, 6);

    clr(); xb(32'h600, 32'h680, 32'd7, 32'd7, 3'b010, 1'b0, 1'b0);
    chk("cond_010", 0, 32'h0, 0, 0, 8, 6);
    clr(); xb(32'h600, 32'h680, 32'd7, 32'd8, 3'b011, 1'b1, 1'b0);
    chk("cond_011", 1, 32'h604, 1, 0, 8, 6);
    clr(); xb(32'h700, 32'h780, 32'd1, 32'hFFFF_FFFF, BGE, 1'b1, 1'b0);
    chk("bge_signed", 0, 32'h0, 0, 0, 8, 6);
    clr(); xb(32'h700, 32'h780, 32'd1, 32'hFFFF_FFFF, BGEU, 1'b1, 1'b0);
    chk("bgeu_unsigned", 1, 32'h704, 1, 0, 8, 6);
    clr(); xb(32'hFFFF_FFFC, 32'h10, 32'd3, 32'd3, BNE, 1'b1, 1'b0);
    chk("pc_plus4_wrap", 1, 32'h0, 1, 0, 8, 6);
    clr(); dset(32'h100, 32'h40); d.valid = 1'b0;
    chk("d_invalid", 0, 32'h0, 0, 0, 8, 6);

    clr(); dset(32'h100, 32'h40);
    chk("pre_reset_pred", PRED, PRED ? 32'h140 : 32'h0, 0, PRED, 8, 6);
    clr(); dset(32'h100, 32'h40); rst_n = 1'b0;
    chk("async_reset", 0, 32'h0, 0, 0, 0, 0);
    rst_n = 1'b1;
    clr(); dset(32'h100, 32'h40);
    chk("post_reset_pred", 0, 32'h0, 0, 0, 0, 0);

    clr();
    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      @(posedge clk);
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
